// File: rtl/dma_rd_pkg.sv
// rtl/dma_rd_pkg.sv - shared types, MRd header constants and MRRS decode for the DMA read request generator
package dma_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CALC    = 3'd1,
        ST_WAIT_CR = 3'd2,
        ST_REQ     = 3'd3,
        ST_HDR     = 3'd4
    } rd_state_e;

    localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
    localparam logic [1:0] FMT_4DW_NODATA = 2'b01;
    localparam logic [4:0] TYPE_MRD       = 5'b00000;

    localparam int HDR3_BITS = 96;
    localparam int HDR4_BITS = 128;

    // MRRS code n means 128 << n bytes, never more than the build-time cap
    function automatic logic [12:0] mrrs_bytes(input logic [2:0] code, input int unsigned max_bytes);
        int unsigned b;
        b = 32'd128 << code;
        if (b > max_bytes) b = max_bytes;
        return 13'(b);
    endfunction

endpackage

// File: rtl/dma_tag_pool.sv
// rtl/dma_tag_pool.sv - tag free bitmap, lowest-free allocator, tag->channel map and outstanding count
module dma_tag_pool #(
    parameter int TAG_W = 5
) (
    input  logic             clk_125,
    input  logic             rstn,
    input  logic             alloc_i,
    input  logic [2:0]       alloc_ch_i,
    input  logic             free_vld_i,
    input  logic [TAG_W-1:0] free_tag_i,
    input  logic [TAG_W-1:0] lkup_tag_i,
    output logic             avail_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    output logic [2:0]       lkup_ch_o,
    output logic [TAG_W:0]   tags_out_o,
    output logic             err_tag_o
);

    localparam int NT = 1 << TAG_W;

    logic [NT-1:0]  busy_q;
    logic [2:0]     map_q [NT];
    logic [2:0]     lkup_ch_q;
    logic [TAG_W:0] cnt_q;
    logic           err_q;
    logic           free_hit_c;

    assign free_hit_c = free_vld_i & busy_q[free_tag_i];

    // scan downward so the lowest free tag is the one left standing
    always_comb begin
        avail_o     = 1'b0;
        alloc_tag_o = '0;
        for (int t = NT - 1; t >= 0; t--) begin
            if (!busy_q[t]) begin
                avail_o     = 1'b1;
                alloc_tag_o = TAG_W'(t);
            end
        end
    end

    always_ff @(posedge clk_125) begin
        if (!rstn) begin
            busy_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            lkup_ch_q <= '0;
            for (int t = 0; t < NT; t++) map_q[t] <= '0;
        end else begin
            if (free_hit_c) busy_q[free_tag_i] <= 1'b0;
            if (free_vld_i && !busy_q[free_tag_i]) err_q <= 1'b1;
            if (alloc_i) begin
                busy_q[alloc_tag_o] <= 1'b1;
                map_q[alloc_tag_o]  <= alloc_ch_i;
            end
            case ({alloc_i, free_hit_c})
                2'b10:   cnt_q <= cnt_q + (TAG_W + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (TAG_W + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            lkup_ch_q <= map_q[lkup_tag_i];
        end
    end

    assign lkup_ch_o  = lkup_ch_q;
    assign tags_out_o = cnt_q;
    assign err_tag_o  = err_q;

endmodule

// File: rtl/dma_rd_req_gen.sv
// rtl/dma_rd_req_gen.sv - multi-channel PCIe MRd request generator; DMA_RD_64B_ADDR_EN enables 64-bit addresses / 4DW headers
module dma_rd_req_gen
    import dma_rd_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 16,
    parameter int LEN_W        = 16,
    parameter int TAG_W        = 5,
    parameter int MAX_RD_BYTES = 512,
`ifdef DMA_RD_64B_ADDR_EN
    localparam int ADDR_W      = 64
`else
    localparam int ADDR_W      = 32
`endif
) (
    input  logic                     clk_125,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic [15:0]              requestor_id,
    input  logic [2:0]               max_rd_req_sz,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*LEN_W-1:0]  ch_len,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH-1:0]        ch_done,
    output logic                     tx_req,
    input  logic                     tx_rdy,
    output logic                     tx_st,
    output logic                     tx_end,
    output logic [DATA_W-1:0]        tx_data,
    input  logic [8:0]               tx_ca_nph,
    input  logic                     tag_free_vld,
    input  logic [TAG_W-1:0]         tag_free,
    input  logic [TAG_W-1:0]         lkup_tag,
    output logic [2:0]               lkup_ch,
    output logic [TAG_W:0]           tags_out,
    output logic                     err_tag,
    output logic                     busy
);

    localparam logic [3:0]        BEATS3    = 4'(HDR3_BITS / DATA_W);
    localparam logic [3:0]        BEATS4    = 4'(HDR4_BITS / DATA_W);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);
    localparam logic [LEN_W-1:0]  LEN_MASK  = ~LEN_W'(3);

    rd_state_e          state_q;
    logic [ADDR_W-1:0]  addr_q [8];
    logic [LEN_W-1:0]   rem_q  [8];
    logic [2:0]         rr_q, cur_q;
    logic [12:0]        seg_q;
    logic [127:0]       hdr_q;
    logic [3:0]         nbeats_q, beat_q;
    logic               tx_req_q, tx_st_q, tx_end_q;
    logic [DATA_W-1:0]  tx_data_q;
    logic [NUM_CH-1:0]  ch_ack_q, ch_done_q;

    logic [ADDR_W-1:0]  ld_addr_c [NUM_CH];
    logic [LEN_W-1:0]   ld_len_c  [NUM_CH];
    logic               grant_vld_c, any_rem_c;
    logic [2:0]         grant_ch_c;
    logic [ADDR_W-1:0]  cur_addr_c;
    logic [12:0]        mrrs_c, bnd_c, lim_c, seg_c;
    logic [31:0]        rem32_c;
    logic               credit_ok_c, alloc_c, tag_avail_c;
    logic [TAG_W-1:0]   alloc_tag_c;
    logic [31:0]        dw1_c;
    logic [3:0]         lbe_c;
    logic [127:0]       hdr_c;
    logic [3:0]         nbeats_c;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ld_addr_c[i] = ch_addr[i*ADDR_W +: ADDR_W] & ADDR_MASK;
            ld_len_c[i]  = ch_len[i*LEN_W +: LEN_W] & LEN_MASK;
        end
    end

    // round-robin: first channel with work at or after the pointer
    always_comb begin
        grant_vld_c = 1'b0;
        grant_ch_c  = '0;
        any_rem_c   = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (rem_q[3'(idx)] != '0) begin
                grant_vld_c = 1'b1;
                grant_ch_c  = 3'(idx);
                any_rem_c   = 1'b1;
            end
        end
    end

    assign cur_addr_c = addr_q[cur_q];

    always_comb begin
        mrrs_c  = mrrs_bytes(max_rd_req_sz, MAX_RD_BYTES);
        bnd_c   = 13'h1000 - {1'b0, cur_addr_c[11:0]};
        lim_c   = (mrrs_c < bnd_c) ? mrrs_c : bnd_c;
        rem32_c = 32'(rem_q[cur_q]);
        seg_c   = (rem32_c < 32'(lim_c)) ? rem32_c[12:0] : lim_c;
    end

    assign credit_ok_c = tx_ca_nph[8] | (tx_ca_nph[7:0] != 8'd0);
    assign alloc_c     = (state_q == ST_WAIT_CR) && credit_ok_c && tag_avail_c;

    assign lbe_c = (seg_q > 13'd4) ? 4'hF : 4'h0;
    assign dw1_c = {requestor_id, 8'(alloc_tag_c), lbe_c, 4'hF};

    // seg_q[11:2] maps a full 4 KB request to the 0 length encoding
    always_comb begin
`ifdef DMA_RD_64B_ADDR_EN
        if (cur_addr_c[63:32] != 32'd0) begin
            hdr_c    = {1'b0, FMT_4DW_NODATA, TYPE_MRD, 14'd0, seg_q[11:2],
                        dw1_c, cur_addr_c[63:32], cur_addr_c[31:2], 2'b00};
            nbeats_c = BEATS4;
        end else begin
            hdr_c    = {1'b0, FMT_3DW_NODATA, TYPE_MRD, 14'd0, seg_q[11:2],
                        dw1_c, cur_addr_c[31:2], 2'b00, 32'd0};
            nbeats_c = BEATS3;
        end
`else
        hdr_c    = {1'b0, FMT_3DW_NODATA, TYPE_MRD, 14'd0, seg_q[11:2],
                    dw1_c, cur_addr_c[31:2], 2'b00, 32'd0};
        nbeats_c = (BEATS4 != 4'd0) ? BEATS3 : BEATS3;
`endif
    end

    always_ff @(posedge clk_125) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            rr_q      <= '0;
            cur_q     <= '0;
            seg_q     <= '0;
            hdr_q     <= '0;
            nbeats_q  <= '0;
            beat_q    <= '0;
            tx_req_q  <= 1'b0;
            tx_st_q   <= 1'b0;
            tx_end_q  <= 1'b0;
            tx_data_q <= '0;
            ch_ack_q  <= '0;
            ch_done_q <= '0;
            for (int k = 0; k < 8; k++) begin
                addr_q[k] <= '0;
                rem_q[k]  <= '0;
            end
        end else begin
            ch_ack_q  <= '0;
            ch_done_q <= '0;

            // the ack cycle is skipped so a held request cannot reload a zero-length job back to back
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_req[i] && rem_q[i] == '0 && !ch_ack_q[i]) begin
                    addr_q[i]   <= ld_addr_c[i];
                    rem_q[i]    <= ld_len_c[i];
                    ch_ack_q[i] <= 1'b1;
                    if (ld_len_c[i] == '0) ch_done_q[i] <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (enable && grant_vld_c) begin
                        cur_q   <= grant_ch_c;
                        rr_q    <= (grant_ch_c == 3'(NUM_CH - 1)) ? 3'd0 : grant_ch_c + 3'd1;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    seg_q   <= seg_c;
                    state_q <= ST_WAIT_CR;
                end
                ST_WAIT_CR: begin
                    if (alloc_c) begin
                        hdr_q    <= hdr_c;
                        nbeats_q <= nbeats_c;
                        tx_req_q <= 1'b1;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tx_rdy) begin
                        tx_req_q  <= 1'b0;
                        tx_st_q   <= 1'b1;
                        tx_data_q <= hdr_q[127 -: DATA_W];
                        hdr_q     <= hdr_q << DATA_W;
                        beat_q    <= 4'd1;
                        tx_end_q  <= (nbeats_q == 4'd1);
                        state_q   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    tx_st_q <= 1'b0;
                    if (tx_end_q) begin
                        tx_end_q      <= 1'b0;
                        tx_data_q     <= '0;
                        addr_q[cur_q] <= cur_addr_c + ADDR_W'(seg_q);
                        rem_q[cur_q]  <= rem_q[cur_q] - LEN_W'(seg_q);
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (3'(i) == cur_q && rem32_c == 32'(seg_q)) ch_done_q[i] <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end else begin
                        tx_data_q <= hdr_q[127 -: DATA_W];
                        hdr_q     <= hdr_q << DATA_W;
                        beat_q    <= beat_q + 4'd1;
                        tx_end_q  <= (beat_q + 4'd1 == nbeats_q);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    dma_tag_pool #(.TAG_W(TAG_W)) u_tag_pool (
        .clk_125    (clk_125),
        .rstn       (rstn),
        .alloc_i    (alloc_c),
        .alloc_ch_i (cur_q),
        .free_vld_i (tag_free_vld),
        .free_tag_i (tag_free),
        .lkup_tag_i (lkup_tag),
        .avail_o    (tag_avail_c),
        .alloc_tag_o(alloc_tag_c),
        .lkup_ch_o  (lkup_ch),
        .tags_out_o (tags_out),
        .err_tag_o  (err_tag)
    );

    assign ch_ack  = ch_ack_q;
    assign ch_done = ch_done_q;
    assign tx_req  = tx_req_q;
    assign tx_st   = tx_st_q;
    assign tx_end  = tx_end_q;
    assign tx_data = tx_data_q;
    assign busy    = any_rem_c | (state_q != ST_IDLE);

endmodule

// File: tb/tb_dma_rd_req_gen.sv
// tb/tb_dma_rd_req_gen.sv - directed self-checking bench for dma_rd_req_gen
module tb_dma_rd_req_gen;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 16;
    localparam int TAG_W  = 5;

    logic                    clk_125 = 1'b0;
    logic                    rstn = 1'b0;
    logic                    enable = 1'b0;
    logic [15:0]             requestor_id = 16'hABCD;
    logic [2:0]              max_rd_req_sz = 3'd0;
    logic [NUM_CH-1:0]       ch_req = '0;
    logic [NUM_CH*32-1:0]    ch_addr = '0;
    logic [NUM_CH*LEN_W-1:0] ch_len = '0;
    logic [NUM_CH-1:0]       ch_ack, ch_done;
    logic                    tx_req, tx_st, tx_end;
    logic                    tx_rdy = 1'b1;
    logic [DATA_W-1:0]       tx_data;
    logic [8:0]              tx_ca_nph = 9'h010;
    logic                    tag_free_vld = 1'b0;
    logic [TAG_W-1:0]        tag_free = '0;
    logic [TAG_W-1:0]        lkup_tag = '0;
    logic [2:0]              lkup_ch;
    logic [TAG_W:0]          tags_out;
    logic                    err_tag, busy;

    int total = 0;
    int bad   = 0;
    int done_cnt [NUM_CH];

    always #5 clk_125 = ~clk_125;

    dma_rd_req_gen #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .LEN_W(LEN_W), .TAG_W(TAG_W), .MAX_RD_BYTES(512)) dut (
        .clk_125(clk_125), .rstn(rstn), .enable(enable), .requestor_id(requestor_id),
        .max_rd_req_sz(max_rd_req_sz), .ch_req(ch_req), .ch_addr(ch_addr), .ch_len(ch_len),
        .ch_ack(ch_ack), .ch_done(ch_done), .tx_req(tx_req), .tx_rdy(tx_rdy), .tx_st(tx_st),
        .tx_end(tx_end), .tx_data(tx_data), .tx_ca_nph(tx_ca_nph), .tag_free_vld(tag_free_vld),
        .tag_free(tag_free), .lkup_tag(lkup_tag), .lkup_ch(lkup_ch), .tags_out(tags_out),
        .err_tag(err_tag), .busy(busy)
    );

    always @(negedge clk_125) begin
        for (int i = 0; i < NUM_CH; i++) if (ch_done[i] === 1'b1) done_cnt[i] = done_cnt[i] + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_job(input int ch, input logic [31:0] a, input logic [15:0] l);
        ch_addr[ch*32 +: 32]   = a;
        ch_len[ch*LEN_W +: 16] = l;
    endtask

    task automatic get_tlp(input string tag, output logic [95:0] h);
        int n;
        n = 0;
        h = '0;
        while (tx_st !== 1'b1 && n < 300) begin
            @(negedge clk_125);
            n++;
        end
        chk({tag, "_start"}, 64'(n < 300), 64'd1);
        if (n < 300) begin
            chk({tag, "_req_low"}, 64'(tx_req), 64'd0);
            for (int b = 0; b < 6; b++) begin
                h = {h[79:0], tx_data};
                if (b == 5) chk({tag, "_end"}, 64'(tx_end), 64'd1);
                @(negedge clk_125);
            end
        end
    endtask

    task automatic exp_tlp(input string tag, input int len, input logic [31:0] addr, input int tg, input logic [7:0] be);
        logic [95:0] h;
        get_tlp(tag, h);
        chk({tag, "_dw0"}, 64'(h[95:64]), 64'({22'd0, 10'(len)}));
        chk({tag, "_dw1"}, 64'(h[63:32]), 64'({16'hABCD, 8'(tg), be}));
        chk({tag, "_dw2"}, 64'(h[31:0]), 64'(addr));
    endtask

    task automatic free_one(input int t);
        tag_free_vld = 1'b1;
        tag_free     = TAG_W'(t);
        @(negedge clk_125);
        tag_free_vld = 1'b0;
    endtask

    task automatic count_req(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_125);
            if (tx_req === 1'b1) c++;
        end
    endtask

    initial begin
        int c;
        int d0, d2;
        logic [95:0] h;

        repeat (3) @(negedge clk_125);
        chk("rst_tx_req", 64'(tx_req), 64'd0);
        chk("rst_tx_st", 64'(tx_st), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tags", 64'(tags_out), 64'd0);
        chk("rst_ack", 64'(ch_ack), 64'd0);
        chk("rst_err", 64'(err_tag), 64'd0);
        rstn   = 1'b1;
        enable = 1'b1;
        @(negedge clk_125);

        // four channels, MRRS 128: strict 0,1,2,3 rotation
        max_rd_req_sz = 3'd0;
        for (int i = 0; i < 4; i++) set_job(i, 32'h2000 + 32'(i) * 32'h1000, 16'd256);
        ch_req = 4'hF;
        @(negedge clk_125);
        chk("rr_ack", 64'(ch_ack), 64'hF);
        ch_req = 4'h0;
        for (int i = 0; i < 8; i++)
            exp_tlp($sformatf("rr%0d", i), 32, 32'h2000 + 32'(i % 4) * 32'h1000 + 32'(i / 4) * 32'h80, i, 8'hFF);
        lkup_tag = 5'd5;
        repeat (2) @(negedge clk_125);
        chk("rr_lkup5", 64'(lkup_ch), 64'd1);
        chk("rr_done0", 64'(done_cnt[0]), 64'd1);
        chk("rr_done3", 64'(done_cnt[3]), 64'd1);
        chk("rr_tags", 64'(tags_out), 64'd8);
        for (int i = 0; i < 8; i++) free_one(i);
        chk("rr_tags_freed", 64'(tags_out), 64'd0);

        // ch0 0x1000 len 1024, MRRS 512
        max_rd_req_sz = 3'd2;
        d0 = done_cnt[0];
        set_job(0, 32'h1000, 16'd1024);
        ch_req = 4'h1;
        @(negedge clk_125);
        chk("j1_ack", 64'(ch_ack), 64'h1);
        ch_req = 4'h0;
        exp_tlp("j1a", 128, 32'h1000, 0, 8'hFF);
        chk("j1_no_early_done", 64'(done_cnt[0] - d0), 64'd0);
        exp_tlp("j1b", 128, 32'h1200, 1, 8'hFF);
        repeat (2) @(negedge clk_125);
        chk("j1_done", 64'(done_cnt[0] - d0), 64'd1);
        free_one(0);
        free_one(1);

        // ch1 0x0F80 len 512: split at the 4 KB boundary
        set_job(1, 32'h0F80, 16'd512);
        ch_req = 4'h2;
        @(negedge clk_125);
        ch_req = 4'h0;
        exp_tlp("j2a", 32, 32'h0F80, 0, 8'hFF);
        exp_tlp("j2b", 96, 32'h1000, 1, 8'hFF);
        free_one(0);
        free_one(1);

        // no credit: hold off, then one credit, then infinite credit
        tx_ca_nph = 9'h000;
        set_job(2, 32'h6000, 16'd4);
        ch_req = 4'h4;
        @(negedge clk_125);
        ch_req = 4'h0;
        count_req(20, c);
        chk("cr_no_req", 64'(c), 64'd0);
        chk("cr_busy", 64'(busy), 64'd1);
        tx_ca_nph = 9'h001;
        exp_tlp("cr_one", 1, 32'h6000, 0, 8'h0F);
        tx_ca_nph = 9'h100;
        set_job(3, 32'h7006, 16'd9);
        ch_req = 4'h8;
        @(negedge clk_125);
        ch_req = 4'h0;
        exp_tlp("cr_inf", 2, 32'h7004, 1, 8'hFF);
        free_one(0);
        free_one(1);

        // exhaust all 32 tags on ch2, then release tag 7
        max_rd_req_sz = 3'd0;
        d2 = done_cnt[2];
        set_job(2, 32'h0001_0000, 16'd4224);
        ch_req = 4'h4;
        @(negedge clk_125);
        ch_req = 4'h0;
        for (int i = 0; i < 32; i++)
            exp_tlp($sformatf("pool%0d", i), 32, 32'h0001_0000 + 32'(i) * 32'h80, i, 8'hFF);
        count_req(20, c);
        chk("pool_stall", 64'(c), 64'd0);
        chk("pool_full", 64'(tags_out), 64'd32);
        free_one(7);
        exp_tlp("pool_t7", 32, 32'h0001_1000, 7, 8'hFF);
        lkup_tag = 5'd7;
        repeat (2) @(negedge clk_125);
        chk("pool_lkup7", 64'(lkup_ch), 64'd2);
        chk("pool_done", 64'(done_cnt[2] - d2), 64'd1);
        free_one(3);
        chk("err_clean", 64'(err_tag), 64'd0);
        chk("tags_31", 64'(tags_out), 64'd31);
        free_one(3);
        chk("err_set", 64'(err_tag), 64'd1);
        chk("tags_still_31", 64'(tags_out), 64'd31);

        // reset on the third header beat
        set_job(0, 32'h8000, 16'd512);
        ch_req = 4'h1;
        @(negedge clk_125);
        ch_req = 4'h0;
        c = 0;
        while (tx_st !== 1'b1 && c < 300) begin
            @(negedge clk_125);
            c++;
        end
        chk("rst_hdr_start", 64'(c < 300), 64'd1);
        repeat (2) @(negedge clk_125);
        rstn = 1'b0;
        @(negedge clk_125);
        chk("mid_rst_st", 64'(tx_st), 64'd0);
        chk("mid_rst_req", 64'(tx_req), 64'd0);
        chk("mid_rst_end", 64'(tx_end), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_tags", 64'(tags_out), 64'd0);
        chk("mid_rst_err", 64'(err_tag), 64'd0);
        rstn = 1'b1;
        @(negedge clk_125);

        // sub-DW job: ack and done together, no TLP
        set_job(1, 32'h9000, 16'd2);
        ch_req = 4'h2;
        @(negedge clk_125);
        chk("short_ack", 64'(ch_ack), 64'h2);
        chk("short_done", 64'(ch_done), 64'h2);
        ch_req = 4'h0;
        count_req(20, c);
        chk("short_no_req", 64'(c), 64'd0);
        chk("short_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
